msg_schedule_ctrl: RTL and testbench

Sequencer for the SHA-256 message schedule. It accepts one 512-bit block as 16 big-endian 32-bit words and stores them in a 16-entry circular word buffer. It then emits the 64 schedule words W0..W63 in order, each through a valid/ready handshake. Words W16..W63 are expanded in place with W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16] (mod 2^32), using instances of MOD_S1 and MOD_S0. It sits between the block-padding front end and the compression round engine.

---
 rtl/msg_schedule_ctrl_if.sv | 21 ++
 rtl/msg_schedule_ctrl.sv | 144 ++++++++++++++
 tb/tb_msg_schedule_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/msg_schedule_ctrl_if.sv
// Handshake bundle for the SHA-256 message schedule sequencer.
// The word input side and the schedule output side share one interface.
interface msg_schedule_ctrl_if;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN_WORD;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_WORD;
  logic [5:0]  OUT_IDX;

  modport slave (
    input  IN_VALID, IN_WORD, OUT_READY,
    output IN_READY, OUT_VALID, OUT_WORD, OUT_IDX
  );

  modport master (
    output IN_VALID, IN_WORD, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_WORD, OUT_IDX
  );
endinterface

// File: rtl/msg_schedule_ctrl.sv
// SHA-256 message schedule: loads 16 words into a circular buffer, then
// emits W0..W63, expanding W16..W63 in place over the same 16 entries.
module MOD_S0 (
  input  logic [31:0] x,
  output logic [31:0] y
);
  assign y = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
endmodule

module MOD_S1 (
  input  logic [31:0] x,
  output logic [31:0] y
);
  assign y = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
endmodule

module msg_schedule_ctrl (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ABORT,
  msg_schedule_ctrl_if.slave   sched,
  output logic                 BUSY,
  output logic                 DONE
);
  typedef enum logic {LOAD, EMIT} state_t;

  state_t      state, state_n;
  logic [3:0]  lc, lc_n;
  logic [5:0]  t, t_n;
  logic        out_valid, out_valid_n;
  logic [31:0] out_word, out_word_n;
  logic        done_n;

  logic [31:0] wbuf [16];
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;

  logic        in_hs, out_hs;
  logic [5:0]  t_nx;
  logic [3:0]  a_m2, a_m7, a_m15, a_m16;
  logic [31:0] s0_out, s1_out, w_exp, w_next;

  assign in_hs  = (state == LOAD) && sched.IN_VALID;
  assign out_hs = out_valid && sched.OUT_READY;

  // Operands for W[t+1], addressed relative to the word currently presented
  assign t_nx  = t + 6'd1;
  assign a_m2  = t[3:0] - 4'd1;
  assign a_m7  = t[3:0] - 4'd6;
  assign a_m15 = t[3:0] + 4'd2;
  assign a_m16 = t[3:0] + 4'd1;

  MOD_S1 u_s1 (.x(wbuf[a_m2]),  .y(s1_out));
  MOD_S0 u_s0 (.x(wbuf[a_m15]), .y(s0_out));

  assign w_exp  = s1_out + wbuf[a_m7] + s0_out + wbuf[a_m16];
  assign w_next = (t_nx[5:4] == 2'b00) ? wbuf[a_m16] : w_exp;

  always_comb begin
    state_n     = state;
    lc_n        = lc;
    t_n         = t;
    out_valid_n = out_valid;
    out_word_n  = out_word;
    done_n      = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = lc;
    wr_data     = sched.IN_WORD;
    if (ABORT) begin
      state_n     = LOAD;
      lc_n        = '0;
      t_n         = '0;
      out_valid_n = 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_hs) begin
            wr_en   = 1'b1;
            wr_addr = lc;
            wr_data = sched.IN_WORD;
            if (lc == 4'd15) begin
              state_n     = EMIT;
              lc_n        = '0;
              t_n         = '0;
              out_valid_n = 1'b1;
              out_word_n  = (lc == 4'd0) ? sched.IN_WORD : wbuf[0];
            end else begin
              lc_n = lc + 4'd1;
            end
          end
        end
        EMIT: begin
          if (out_hs) begin
            // Expanded words replace W[t-16] once consumed
            if (t[5:4] != 2'b00) begin
              wr_en   = 1'b1;
              wr_addr = t[3:0];
              wr_data = out_word;
            end
            if (t == 6'd63) begin
              out_valid_n = 1'b0;
              done_n      = 1'b1;
              state_n     = LOAD;
              t_n         = '0;
            end else begin
              t_n        = t_nx;
              out_word_n = w_next;
            end
          end
        end
        default: state_n = LOAD;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= LOAD;
      lc        <= '0;
      t         <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
      DONE      <= 1'b0;
    end else begin
      state     <= state_n;
      lc        <= lc_n;
      t         <= t_n;
      out_valid <= out_valid_n;
      out_word  <= out_word_n;
      DONE      <= done_n;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) wbuf[wr_addr] <= wr_data;
  end

  assign sched.IN_READY  = (state == LOAD);
  assign sched.OUT_VALID = out_valid;
  assign sched.OUT_WORD  = out_word;
  assign sched.OUT_IDX   = t;
  assign BUSY            = (state != LOAD) || (lc != 4'd0);
endmodule

// File: tb/tb_msg_schedule_ctrl.sv
// Directed bench for msg_schedule_ctrl against a full 64-entry schedule model.
module tb_msg_schedule_ctrl;
  logic CLK = 1'b0;
  logic RST;
  logic ABORT;
  logic BUSY, DONE;

  msg_schedule_ctrl_if sif ();

  msg_schedule_ctrl dut (
    .CLK  (CLK),
    .RST  (RST),
    .ABORT(ABORT),
    .sched(sif.slave),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [31:0] msg   [16];
  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];
  int          done_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic compute_ref();
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) exp_w[i] = msg[i];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(exp_w[i-15], 7) ^ rotr(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3);
      s1 = rotr(exp_w[i-2], 17) ^ rotr(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10);
      exp_w[i] = s1 + exp_w[i-7] + s0 + exp_w[i-16];
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) msg[i] = '0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
    compute_ref();
  endtask

  task automatic set_zero();
    for (int i = 0; i < 16; i++) msg[i] = '0;
    compute_ref();
  endtask

  // Called at a negedge; returns at the negedge after the final accept.
  task automatic do_load(input bit gaps, input int abort_at);
    for (int i = 0; i < 16; i++) begin
      if (gaps && i > 0) begin
        sif.IN_VALID = 1'b0;
        @(negedge CLK);
        check("gap_no_valid", {31'b0, sif.OUT_VALID}, 32'd0);
      end
      check("load_in_ready", {31'b0, sif.IN_READY}, 32'd1);
      sif.IN_VALID = 1'b1;
      sif.IN_WORD  = msg[i];
      if (i == abort_at) ABORT = 1'b1;
      @(negedge CLK);
      if (i == abort_at) begin
        ABORT        = 1'b0;
        sif.IN_VALID = 1'b0;
        check("load_abort_busy",  {31'b0, BUSY},          32'd0);
        check("load_abort_valid", {31'b0, sif.OUT_VALID}, 32'd0);
        check("load_abort_ready", {31'b0, sif.IN_READY},  32'd1);
        return;
      end
      if (i == 0)  check("load_busy", {31'b0, BUSY}, 32'd1);
      if (i < 15) check("load_no_valid", {31'b0, sif.OUT_VALID}, 32'd0);
    end
    sif.IN_VALID = 1'b0;
    check("latency_valid", {31'b0, sif.OUT_VALID}, 32'd1);
  endtask

  // Starts at the negedge where W0 is first presented.
  task automatic do_emit(input bit bp, input int abort_idx, input int rst_idx);
    int          exp_idx = 0;
    int          cyc = 0;
    bit          hold = 1'b0;
    bit          last_hs = 1'b0;
    bit          fin = 1'b0;
    logic [31:0] hw;
    logic [5:0]  hi;
    done_cyc = -1;
    while (!fin && cyc < 2000) begin
      if (last_hs) begin
        check("done_pulse",     {31'b0, DONE},          32'd1);
        check("done_valid_low", {31'b0, sif.OUT_VALID}, 32'd0);
        check("done_in_ready",  {31'b0, sif.IN_READY},  32'd1);
        done_cyc = cyc;
        sif.OUT_READY = 1'b0;
        fin = 1'b1;
      end else begin
        check("emit_done_low", {31'b0, DONE},          32'd0);
        check("emit_valid",    {31'b0, sif.OUT_VALID}, 32'd1);
        if (hold) begin
          check("hold_word", sif.OUT_WORD,        hw);
          check("hold_idx",  {26'b0, sif.OUT_IDX}, {26'b0, hi});
        end
        check("emit_idx",  {26'b0, sif.OUT_IDX}, exp_idx);
        check("emit_word", sif.OUT_WORD, exp_w[exp_idx]);
        got_w[exp_idx] = sif.OUT_WORD;
        if (exp_idx == rst_idx) begin
          sif.OUT_READY = 1'b0;
          #1 RST = 1'b1;
          #1;
          check("rst_valid",    {31'b0, sif.OUT_VALID}, 32'd0);
          check("rst_done",     {31'b0, DONE},          32'd0);
          check("rst_idx",      {26'b0, sif.OUT_IDX},   32'd0);
          check("rst_word",     sif.OUT_WORD,           32'd0);
          check("rst_busy",     {31'b0, BUSY},          32'd0);
          check("rst_in_ready", {31'b0, sif.IN_READY},  32'd1);
          @(negedge CLK);
          RST = 1'b0;
          fin = 1'b1;
        end else begin
          sif.OUT_READY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
          if (sif.OUT_READY) begin
            hold = 1'b0;
            if (exp_idx == abort_idx) begin
              ABORT = 1'b1;
              @(negedge CLK);
              ABORT         = 1'b0;
              sif.OUT_READY = 1'b0;
              check("abort_valid", {31'b0, sif.OUT_VALID}, 32'd0);
              check("abort_done",  {31'b0, DONE},          32'd0);
              check("abort_busy",  {31'b0, BUSY},          32'd0);
              @(negedge CLK);
              check("abort_no_done", {31'b0, DONE}, 32'd0);
              fin = 1'b1;
            end else begin
              if (exp_idx == 63) last_hs = 1'b1;
              else exp_idx++;
            end
          end else begin
            hold = 1'b1;
            hw   = sif.OUT_WORD;
            hi   = sif.OUT_IDX;
          end
        end
      end
      if (!fin) begin
        @(negedge CLK);
        cyc++;
      end
    end
    total++;
    assert (fin) else begin
      bad++;
      $error("FAIL emit_timeout observed=%0d expected=%0d", fin, 1);
    end
  endtask

  task automatic after_done();
    @(negedge CLK);
    check("done_once", {31'b0, DONE}, 32'd0);
  endtask

  task automatic full_block(input bit bp, input bit gaps);
    do_load(gaps, -1);
    do_emit(bp, -1, -1);
    after_done();
  endtask

  initial begin
    RST           = 1'b1;
    ABORT         = 1'b0;
    sif.IN_VALID  = 1'b0;
    sif.IN_WORD   = '0;
    sif.OUT_READY = 1'b0;
    #3;
    check("reset_valid",    {31'b0, sif.OUT_VALID}, 32'd0);
    check("reset_done",     {31'b0, DONE},          32'd0);
    check("reset_busy",     {31'b0, BUSY},          32'd0);
    check("reset_in_ready", {31'b0, sif.IN_READY},  32'd1);
    check("reset_idx",      {26'b0, sif.OUT_IDX},   32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // "abc" block, no backpressure
    set_abc();
    do_load(1'b0, -1);
    do_emit(1'b0, -1, -1);
    check("abc_done_cycle", done_cyc, 32'd64);
    check("abc_w0",  got_w[0],  32'h61626380);
    check("abc_w15", got_w[15], 32'h00000018);
    check("abc_w16", got_w[16], 32'h61626380);
    check("abc_w17", got_w[17], 32'h000F0000);
    after_done();

    // All-zero block
    set_zero();
    full_block(1'b0, 1'b0);

    // Random backpressure on "abc"
    set_abc();
    full_block(1'b1, 1'b0);

    // Input gaps on "abc"
    full_block(1'b0, 1'b1);

    // Abort at the 10th accept, then a full block
    do_load(1'b0, 9);
    @(negedge CLK);
    full_block(1'b0, 1'b0);

    // Abort at the t=40 handshake, then a full block
    do_load(1'b0, -1);
    do_emit(1'b0, 40, -1);
    full_block(1'b0, 1'b0);

    // Async reset mid-emit at t=20, then a fresh block
    do_load(1'b0, -1);
    do_emit(1'b0, -1, 20);
    @(negedge CLK);
    check("post_rst_in_ready", {31'b0, sif.IN_READY}, 32'd1);
    full_block(1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
